i2c_slave_regbank: RTL and testbench

Parametrised I2C target with an internal byte-addressed register bank, auto-incrementing register pointer, repeated-START support and read-back. Successor to the single-byte `i2c_slave`. Sits on the same shared SDA/SCL bus as `i2c_master` and exposes a local port for the host logic to observe writes and read bank contents.

---
 rtl/i2c_pkg.sv | 31 +++
 rtl/i2c_slave_regbank_if.sv | 15 +
 rtl/i2c_bus_sync.sv | 88 ++++++++
 rtl/i2c_slave_regbank.sv | 247 ++++++++++++++++++++++++
 tb/tb_i2c_slave_regbank.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C target/master definitions
//
// Purpose: FSM state encoding, ACK/NACK bus levels and the bit positions of the
// 7-bit address and R/W flag inside the address byte.
// Ports: none (package).
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } i2c_state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam int ADDR_MSB = 7;
  localparam int ADDR_LSB = 1;
  localparam int RW_BIT   = 0;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_slave_regbank_if.sv
// rtl/i2c_slave_regbank_if.sv - shared SDA/SCL bus bundle
//
// Purpose: groups the I2C pin-level signals of one target.
// Signals: scl (bus clock), sda (resolved bus data), sda_out (value driven while
// sda_oe=1), sda_oe (SDA drive enable).
// Modports: master (drives scl/sda, observes target drive), slave (the target).
interface i2c_slave_regbank_if;
  logic scl;
  logic sda;
  logic sda_out;
  logic sda_oe;

  modport master (output scl, output sda, input sda_out, input sda_oe);
  modport slave  (input scl, input sda, output sda_out, output sda_oe);
endinterface

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchroniser, optional glitch filter, edge and START/STOP detect
//
// Purpose: brings the asynchronous bus pins into the clk domain and flags
// SCL edges plus START (SDA falls, SCL high) and STOP (SDA rises, SCL high).
// Optional macro I2C_GLITCH_FILTER_EN: 3-sample majority filter behind the
// synchroniser, rejecting pulses of 1 clk and adding 1 clk of latency.
// Ports:
//   clk, reset        system clock, async active-low reset
//   scl_pin, sda_pin  raw bus inputs
//   sda               conditioned SDA level
//   scl_rise/scl_fall one-cycle SCL edge strobes
//   start_det/stop_det one-cycle bus condition strobes
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_pin,
  input  logic sda_pin,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic scl_f;
  logic sda_f;
  logic scl_prev;
  logic sda_prev;

  // Reset to the idle bus level so leaving reset never looks like an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_pin};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_pin};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [1:0] scl_hist;
  logic [1:0] sda_hist;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[SYNC_STAGES-1]};
      sda_hist <= {sda_hist[0], sda_sync[SYNC_STAGES-1]};
    end
  end

  assign scl_f = maj3(scl_sync[SYNC_STAGES-1], scl_hist[0], scl_hist[1]);
  assign sda_f = maj3(sda_sync[SYNC_STAGES-1], sda_hist[0], sda_hist[1]);
`else
  assign scl_f = scl_sync[SYNC_STAGES-1];
  assign sda_f = sda_sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_prev <= scl_f;
      sda_prev <= sda_f;
    end
  end

  assign sda       = sda_f;
  assign scl_rise  = scl_f & ~scl_prev;
  assign scl_fall  = ~scl_f & scl_prev;
  // SCL must be high in both samples so an SDA change coinciding with an
  // SCL fall is never mistaken for a bus condition.
  assign start_det = scl_f & scl_prev & sda_prev & ~sda_f;
  assign stop_det  = scl_f & scl_prev & ~sda_prev & sda_f;

endmodule

// File: rtl/i2c_slave_regbank.sv
// rtl/i2c_slave_regbank.sv - I2C target with auto-incrementing register bank
//
// Purpose: byte-addressed bank of REG_DEPTH registers reachable over I2C;
// first write byte loads the pointer, later bytes write and auto-increment,
// reads stream from the pointer. Pointer persists across transactions.
// Optional macro I2C_GLITCH_FILTER_EN (see i2c_bus_sync).
// Ports:
//   clk, reset         system clock, async active-low reset
//   bus                SDA/SCL bundle (slave modport)
//   slave_addr         7-bit target address, static
//   busy               addressed and active until STOP/NACK/other START
//   wr_valid           one-cycle pulse per committed write
//   wr_addr, wr_data   last written register and byte
//   rd_addr, rd_data   local read port, one-cycle latency
module i2c_slave_regbank
  import i2c_pkg::*;
#(
  parameter int REG_DEPTH   = 16,
  parameter int PTR_W       = $clog2(REG_DEPTH),
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  i2c_slave_regbank_if.slave bus,
  input  logic [6:0]        slave_addr,
  output logic              busy,
  output logic              wr_valid,
  output logic [PTR_W-1:0]  wr_addr,
  output logic [7:0]        wr_data,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [7:0]        rd_data
);

  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_pin   (bus.scl),
    .sda_pin   (bus.sda),
    .sda       (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_state_t       state_q, state_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       txreg_q, txreg_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             oe_q, oe_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             wr_pend_q, wr_pend_d;

  logic [7:0] bank [REG_DEPTH];
  logic [7:0] cur_byte;

  assign cur_byte = bank[ptr_q];

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(REG_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      txreg_q   <= '0;
      ptr_q     <= '0;
      oe_q      <= 1'b0;
      out_q     <= 1'b1;
      busy_q    <= 1'b0;
      wr_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      txreg_q   <= txreg_d;
      ptr_q     <= ptr_d;
      oe_q      <= oe_d;
      out_q     <= out_d;
      busy_q    <= busy_d;
      wr_pend_q <= wr_pend_d;
    end
  end

  // Drive changes are only made on scl_fall strobes, so SDA never moves
  // while SCL is high. bitcnt==8 marks "byte received, waiting for the fall
  // that opens the ACK slot".
  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    txreg_d   = txreg_q;
    ptr_d     = ptr_q;
    oe_d      = oe_q;
    out_d     = out_q;
    busy_d    = busy_q;
    wr_pend_d = 1'b0;

    // The write commit of the previous cycle advances the pointer.
    if (wr_pend_q) ptr_d = ptr_next(ptr_q);

    if (stop_det) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      out_d   = 1'b1;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d  = ADDR;
      bitcnt_d = '0;
      oe_d     = 1'b0;
      out_d    = 1'b1;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise && bitcnt_q != 4'd8) begin
            shreg_d  = {shreg_q[6:0], sda_s};
            bitcnt_d = bitcnt_q + 4'd1;
            if (state_q == WDATA && bitcnt_q == 4'd7) wr_pend_d = 1'b1;
          end else if (scl_fall && bitcnt_q == 4'd8) begin
            bitcnt_d = '0;
            if (state_q == ADDR) begin
              if (shreg_q[ADDR_MSB:ADDR_LSB] == slave_addr) begin
                state_d = ADDR_ACK;
                oe_d    = 1'b1;
                out_d   = ACK;
                busy_d  = 1'b1;
              end else begin
                state_d = IGNORE;
                busy_d  = 1'b0;
              end
            end else if (state_q == PTR) begin
              if ({1'b0, shreg_q} < 9'(REG_DEPTH)) begin
                state_d = PTR_ACK;
                ptr_d   = shreg_q[PTR_W-1:0];
                oe_d    = 1'b1;
                out_d   = ACK;
              end else begin
                state_d = IGNORE;
                busy_d  = 1'b0;
              end
            end else begin
              state_d = WDATA_ACK;
              oe_d    = 1'b1;
              out_d   = ACK;
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            bitcnt_d = '0;
            if (shreg_q[RW_BIT] == RW_WRITE) begin
              state_d = PTR;
              oe_d    = 1'b0;
              out_d   = 1'b1;
            end else begin
              state_d = RDATA;
              txreg_d = {cur_byte[6:0], 1'b0};
              out_d   = cur_byte[7];
              ptr_d   = ptr_next(ptr_q);
            end
          end
        end

        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            state_d  = WDATA;
            bitcnt_d = '0;
            oe_d     = 1'b0;
            out_d    = 1'b1;
          end
        end

        RDATA: begin
          if (scl_fall) begin
            if (bitcnt_q == 4'd7) begin
              state_d  = RDATA_ACK;
              bitcnt_d = '0;
              oe_d     = 1'b0;
              out_d    = 1'b1;
            end else begin
              out_d    = txreg_q[7];
              txreg_d  = {txreg_q[6:0], 1'b0};
              bitcnt_d = bitcnt_q + 4'd1;
            end
          end
        end

        // bitcnt==1 records a master ACK seen on the rising edge.
        RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_s == NACK) begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end else begin
              bitcnt_d = 4'd1;
            end
          end else if (scl_fall && bitcnt_q == 4'd1) begin
            state_d  = RDATA;
            bitcnt_d = '0;
            txreg_d  = {cur_byte[6:0], 1'b0};
            oe_d     = 1'b1;
            out_d    = cur_byte[7];
            ptr_d    = ptr_next(ptr_q);
          end
        end

        default: ;
      endcase
    end
  end

  // Bank write lands one cycle after the byte is complete; rd_data reads the
  // bank on the same edge so it shows the old value first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_DEPTH; i++) bank[i] <= 8'h00;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      rd_data  <= '0;
    end else begin
      wr_valid <= wr_pend_q;
      if (wr_pend_q) begin
        bank[ptr_q] <= shreg_q;
        wr_addr     <= ptr_q;
        wr_data     <= shreg_q;
      end
      rd_data <= bank[rd_addr];
    end
  end

  assign bus.sda_oe  = oe_q;
  assign bus.sda_out = out_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_i2c_slave_regbank.sv
// tb/tb_i2c_slave_regbank.sv - scoreboard bench for i2c_slave_regbank
module tb_i2c_slave_regbank;
  import i2c_pkg::*;

  localparam int REG_DEPTH   = 16;
  localparam int PTR_W       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int TQ          = 5;
  localparam logic [6:0] SLV = 7'h42;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic             busy;
  logic             wr_valid;
  logic [PTR_W-1:0] wr_addr;
  logic [7:0]       wr_data;
  logic [PTR_W-1:0] rd_addr = '0;
  logic [7:0]       rd_data;

  i2c_slave_regbank_if bus ();

  assign bus.scl = m_scl;
  assign bus.sda = m_sda & ~(bus.sda_oe & ~bus.sda_out);

  i2c_slave_regbank #(
    .REG_DEPTH   (REG_DEPTH),
    .PTR_W       (PTR_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .slave_addr (SLV),
    .busy       (busy),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        exp_wr[$];
  logic [7:0] exp_rd[$];
  logic [7:0] rx_q[$];
  int checks = 0;
  int errors = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic exp_write(input logic [3:0] a, input logic [7:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_wr.push_back(e);
  endtask

  // Scoreboard monitor: write pulses and master-received bytes.
  always @(negedge clk) begin
    wr_t e;
    if (reset && wr_valid) begin
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected actual=%0h/%0h required=none", wr_addr, wr_data);
      end else begin
        e = exp_wr.pop_front();
        check("wr_addr", wr_addr, e.a);
        check("wr_data", wr_data, e.d);
      end
    end
    if (rx_q.size() > 0) begin
      if (exp_rd.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected actual=%0h required=none", rx_q.pop_front());
      end else begin
        check("rd_byte", rx_q.pop_front(), exp_rd.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (bus.sda_oe) oe_cnt <= oe_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  initial begin
    repeat (40000) @(posedge clk);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wait_clk(TQ);
    m_scl = 1'b1; wait_clk(TQ);
    m_sda = 1'b0; wait_clk(TQ);
    m_scl = 1'b0; wait_clk(TQ);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_clk(TQ);
    m_scl = 1'b1; wait_clk(TQ);
    m_sda = 1'b1; wait_clk(2 * TQ);
  endtask

  task automatic clock_bit(input logic b, input int glitch, output logic s);
    m_sda = b;    wait_clk(TQ);
    m_scl = 1'b1; wait_clk(3);
    if (glitch != 0) begin
      m_scl = 1'b0; wait_clk(1);
      m_scl = 1'b1;
    end
    wait_clk(2);
    s = bus.sda;
    wait_clk(5);
    m_scl = 1'b0; wait_clk(2);
  endtask

  task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], (i == glitch_bit) ? 1 : 0, s);
    clock_bit(1'b1, 0, ack);
  endtask

  task automatic send(input string name, input logic [7:0] b, input logic exp_ack);
    logic a;
    write_byte(b, -1, a);
    check(name, a, exp_ack);
  endtask

  task automatic read_byte(input logic mack);
    logic [7:0] d;
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(1'b1, 0, d[i]);
    clock_bit(mack, 0, s);
    rx_q.push_back(d);
  endtask

  initial begin
    logic s;
    logic a;
    int oe0;
    int busy0;

    reset = 1'b0;
    wait_clk(3);
    check("rst_sda_oe", bus.sda_oe, 0);
    check("rst_sda_out", bus.sda_out, 1);
    check("rst_busy", busy, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_rd_data", rd_data, 0);
    reset = 1'b1;
    wait_clk(4);

    // Burst write from pointer 3
    i2c_start();
    send("t1_addr_ack", 8'h84, ACK);
    check("t1_busy", busy, 1);
    send("t1_ptr_ack", 8'h03, ACK);
    exp_write(4'h3, 8'hAA); send("t1_d0_ack", 8'hAA, ACK);
    exp_write(4'h4, 8'hBB); send("t1_d1_ack", 8'hBB, ACK);
    exp_write(4'h5, 8'hCC); send("t1_d2_ack", 8'hCC, ACK);
    i2c_stop();
    check("t1_busy_after_stop", busy, 0);
    check("t1_wr_addr_held", wr_addr, 5);
    check("t1_wr_data_held", wr_data, 8'hCC);
    rd_addr = 4'd4; wait_clk(2);
    check("t1_rd4", rd_data, 8'hBB);

    // Pointer wrap on write
    i2c_start();
    send("t2_addr_ack", 8'h84, ACK);
    send("t2_ptr_ack", 8'h0F, ACK);
    exp_write(4'hF, 8'h11); send("t2_d0_ack", 8'h11, ACK);
    exp_write(4'h0, 8'h22); send("t2_d1_ack", 8'h22, ACK);
    i2c_stop();
    rd_addr = 4'd15; wait_clk(2);
    check("t2_rd15", rd_data, 8'h11);
    rd_addr = 4'd0; wait_clk(2);
    check("t2_rd0", rd_data, 8'h22);

    // Repeated-START read of bank[5], bank[6]
    i2c_start();
    send("t3_addr_ack", 8'h84, ACK);
    send("t3_ptr_ack", 8'h06, ACK);
    exp_write(4'h6, 8'h96); send("t3_d0_ack", 8'h96, ACK);
    i2c_stop();
    i2c_start();
    send("t3_addr2_ack", 8'h84, ACK);
    send("t3_ptr2_ack", 8'h05, ACK);
    i2c_start();
    send("t3_raddr_ack", 8'h85, ACK);
    exp_rd.push_back(8'hCC);
    exp_rd.push_back(8'h96);
    read_byte(ACK);
    read_byte(NACK);
    wait_clk(4);
    check("t3_sda_released", bus.sda_oe, 0);
    check("t3_busy_after_nack", busy, 0);
    i2c_stop();

    // Foreign address: never driven, never busy
    oe0 = oe_cnt;
    busy0 = busy_cnt;
    i2c_start();
    send("t4_addr_nack", 8'h86, NACK);
    send("t4_data_nack", 8'h5A, NACK);
    i2c_stop();
    check("t4_sda_never_driven", oe_cnt, oe0);
    check("t4_busy_never", busy_cnt, busy0);

    // Out-of-range pointer
    i2c_start();
    send("t5_addr_ack", 8'h84, ACK);
    send("t5_ptr_nack", 8'h20, NACK);
    check("t5_busy_after_nack", busy, 0);
    send("t5_data_nack", 8'h99, NACK);
    i2c_stop();
    rd_addr = 4'd0; wait_clk(2);
    check("t5_rd0_kept", rd_data, 8'h22);

    // Reset mid-read, during the 4th data bit
    i2c_start();
    send("t6_addr_ack", 8'h84, ACK);
    send("t6_ptr_ack", 8'h05, ACK);
    i2c_start();
    send("t6_raddr_ack", 8'h85, ACK);
    for (int i = 0; i < 3; i++) clock_bit(1'b1, 0, s);
    m_sda = 1'b1; wait_clk(TQ);
    m_scl = 1'b1; wait_clk(3);
    check("t6_oe_before_reset", bus.sda_oe, 1);
    reset = 1'b0;
    #1;
    check("t6_oe_async_release", bus.sda_oe, 0);
    check("t6_sda_out_reset", bus.sda_out, 1);
    check("t6_busy_reset", busy, 0);
    wait_clk(3);
    m_scl = 1'b1;
    m_sda = 1'b1;
    reset = 1'b1;
    rd_addr = 4'd5;
    wait_clk(4);
    check("t6_bank_cleared", rd_data, 8'h00);
    i2c_start();
    send("t6_addr2_ack", 8'h84, ACK);
    send("t6_ptr2_ack", 8'h02, ACK);
    exp_write(4'h2, 8'h5A); send("t6_d_ack", 8'h5A, ACK);
    i2c_stop();
    i2c_start();
    send("t6_addr3_ack", 8'h84, ACK);
    send("t6_ptr3_ack", 8'h02, ACK);
    i2c_start();
    send("t6_raddr2_ack", 8'h85, ACK);
    exp_rd.push_back(8'h5A);
    read_byte(NACK);
    i2c_stop();

`ifdef I2C_GLITCH_FILTER_EN
    // 1-clk SCL low glitch inside a data bit must not shift a bit
    i2c_start();
    send("t7_addr_ack", 8'h84, ACK);
    send("t7_ptr_ack", 8'h09, ACK);
    exp_write(4'h9, 8'h3C);
    write_byte(8'h3C, 4, a);
    check("t7_d_ack", a, ACK);
    i2c_stop();
`else
    a = ACK;
`endif

    wait_clk(10);
    check("wr_queue_drained", exp_wr.size(), 0);
    check("rd_queue_drained", exp_rd.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
